// File: rtl/mem_responder.sv
// mem_responder: shared single-port storage serving one load/store port and
// RPORTS instruction-fetch read ports with a one-cycle access latency.
// The load/store port always has priority. Read ports are arbitrated by fixed
// priority (lowest index wins). When MEM_RR_ARB_EN is defined, read ports are
// arbitrated round-robin instead, with the pointer moving to one past the
// port that was granted.
// Storage is never cleared by reset. Only in-flight and response state is
// cleared.

`ifndef MEM_RPORTS
`define MEM_RPORTS 2
`endif

module mem_responder #(
    parameter int unsigned RPORTS = `MEM_RPORTS,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned AW    = 8,
    localparam int unsigned DW    = 16
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    // instruction-fetch read ports
    input  logic [RPORTS-1:0]             i_mem_r_val,
    input  logic [RPORTS-1:0][AW-1:0]     i_mem_r_addr,
    output logic [RPORTS-1:0]             o_mem_r_rdy,
    output logic [RPORTS-1:0][DW-1:0]     o_mem_r_data,
    // load/store port
    input  logic                          i_mem_rw_val,
    input  logic                          i_mem_rw_wen,
    input  logic [AW-1:0]                 i_mem_rw_addr,
    input  logic [DW-1:0]                 i_mem_rw_wdata,
    output logic                          o_mem_rw_rdy,
    output logic [DW-1:0]                 o_mem_rw_rdata
);

    localparam int unsigned PW = (RPORTS > 1) ? $clog2(RPORTS) : 1;

    // storage and response registers
    logic [DW-1:0]             r_mem [DEPTH];
    logic                      r_alive;
    logic                      r_rw_rdy;
    logic [DW-1:0]             r_rw_rdata;
    logic [RPORTS-1:0]         r_r_rdy;
    logic [RPORTS-1:0][DW-1:0] r_r_data;

    // arbitration and datapath wires
    logic [RPORTS-1:0]         w_r_elig;
    logic                      w_gnt_rw;
    logic                      w_gnt_rd;
    logic [PW-1:0]             w_gnt_idx;
    logic [AW-1:0]             w_addr;
    logic                      w_wr_en;
    logic [DW-1:0]             w_rd_word;

`ifdef MEM_RR_ARB_EN
    logic [PW-1:0]             r_ptr;

    // Returns the read port index that lies ofs positions after ptr, wrapping at RPORTS.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] ptr, input int ofs);
        int s;
        s = int'(ptr) + ofs;
        if (s >= int'(RPORTS)) begin
            s = s - int'(RPORTS);
        end
        return PW'(s);
    endfunction
`endif

    // Grant one requester per cycle. A port is excluded while its rdy is high.
    // r_alive is cleared asynchronously, so a grant cannot occur in a reset cycle.
    always_comb begin
        w_r_elig  = i_mem_r_val & ~r_r_rdy & {RPORTS{r_alive}};
        w_gnt_rw  = i_mem_rw_val & ~r_rw_rdy & r_alive;
        w_gnt_rd  = 1'b0;
        w_gnt_idx = '0;
        if (!w_gnt_rw) begin
`ifdef MEM_RR_ARB_EN
            for (int k = int'(RPORTS) - 1; k >= 0; k--) begin
                if (w_r_elig[rr_idx(r_ptr, k)]) begin
                    w_gnt_rd  = 1'b1;
                    w_gnt_idx = rr_idx(r_ptr, k);
                end
            end
`else
            for (int i = int'(RPORTS) - 1; i >= 0; i--) begin
                if (w_r_elig[i]) begin
                    w_gnt_rd  = 1'b1;
                    w_gnt_idx = PW'(i);
                end
            end
`endif
        end
    end

    // Select the address of the granted port and perform a single array access.
    always_comb begin
        w_addr    = w_gnt_rw ? i_mem_rw_addr : i_mem_r_addr[w_gnt_idx];
        w_wr_en   = w_gnt_rw & i_mem_rw_wen;
        w_rd_word = r_mem[w_addr];
    end

    // Commit the store at the end of the grant cycle.
    // The array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_addr] <= i_mem_rw_wdata;
        end
    end

    // Register the completion pulse and data for the granted port.
    // All other ports are forced to zero.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_alive    <= 1'b0;
            r_rw_rdy   <= 1'b0;
            r_rw_rdata <= '0;
            r_r_rdy    <= '0;
            r_r_data   <= '0;
        end else begin
            r_alive    <= 1'b1;
            r_rw_rdy   <= w_gnt_rw;
            r_rw_rdata <= w_gnt_rw ? (i_mem_rw_wen ? i_mem_rw_wdata : w_rd_word) : '0;
            for (int i = 0; i < int'(RPORTS); i++) begin
                r_r_rdy[i]  <= w_gnt_rd && (w_gnt_idx == PW'(i));
                r_r_data[i] <= (w_gnt_rd && (w_gnt_idx == PW'(i))) ? w_rd_word : '0;
            end
        end
    end

`ifdef MEM_RR_ARB_EN
    // Advance the round-robin pointer to one past the granted read port.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ptr <= '0;
        end else if (w_gnt_rd) begin
            r_ptr <= (w_gnt_idx == PW'(RPORTS - 1)) ? '0 : PW'(w_gnt_idx + 1'b1);
        end
    end
`endif

    assign o_mem_rw_rdy   = r_rw_rdy;
    assign o_mem_rw_rdata = r_rw_rdata;
    assign o_mem_r_rdy    = r_r_rdy;
    assign o_mem_r_data   = r_r_data;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (default build, fixed-priority reads).
module tb_mem_responder;

    logic              clk_i;
    logic              arst_ni;
    logic [1:0]        r_val;
    logic [1:0][7:0]   r_addr;
    logic [1:0]        r_rdy;
    logic [1:0][15:0]  r_data;
    logic              rw_val;
    logic              rw_wen;
    logic [7:0]        rw_addr;
    logic [15:0]       rw_wdata;
    logic              rw_rdy;
    logic [15:0]       rw_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(.RPORTS(2), .DEPTH(256)) dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .i_mem_r_val    (r_val),
        .i_mem_r_addr   (r_addr),
        .o_mem_r_rdy    (r_rdy),
        .o_mem_r_data   (r_data),
        .i_mem_rw_val   (rw_val),
        .i_mem_rw_wen   (rw_wen),
        .i_mem_rw_addr  (rw_addr),
        .i_mem_rw_wdata (rw_wdata),
        .o_mem_rw_rdy   (rw_rdy),
        .o_mem_rw_rdata (rw_rdata)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_rw(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
        rw_val   = v;
        rw_wen   = w;
        rw_addr  = a;
        rw_wdata = d;
    endtask

    task automatic set_r(input int p, input logic v, input logic [7:0] a);
        r_val[p]  = v;
        r_addr[p] = a;
    endtask

    task automatic do_store(input string tag, input logic [7:0] a, input logic [15:0] d);
        set_rw(1'b1, 1'b1, a, d);
        step();
        check({tag, "_rdy"}, 32'(rw_rdy), 32'd1);
        check({tag, "_rdata"}, 32'(rw_rdata), 32'(d));
        set_rw(1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check({tag, "_quiet"}, {15'd0, rw_rdy, rw_rdata}, 32'd0);
    endtask

    task automatic do_read(input string tag, input int p, input logic [7:0] a, input logic [15:0] d);
        set_r(p, 1'b1, a);
        step();
        check({tag, "_rdy"}, 32'(r_rdy), 32'(2'b01 << p));
        check({tag, "_data"}, 32'(r_data[p]), 32'(d));
        set_r(p, 1'b0, 8'h00);
        step();
        check({tag, "_quiet"}, {14'd0, r_rdy, r_data[p]}, 32'd0);
    endtask

    initial begin
        arst_ni = 1'b0;
        r_val   = '0;
        r_addr  = '0;
        set_rw(1'b0, 1'b0, 8'h00, 16'h0000);

        // reset state
        step();
        check("rst_rw_rdy", 32'(rw_rdy), 32'd0);
        check("rst_rw_rdata", 32'(rw_rdata), 32'd0);
        check("rst_r_rdy", 32'(r_rdy), 32'd0);
        check("rst_r_data", r_data, 32'd0);
        arst_ni = 1'b1;
        step();
        step();

        // initialise locations used later
        do_store("init30", 8'd30, 16'h0000);
        do_store("init7", 8'd7, 16'h7777);

        // store then read back
        do_store("st20", 8'd20, 16'hBEEF);
        do_read("rd20_p0", 0, 8'd20, 16'hBEEF);

        // address FF is ordinary storage
        do_store("stFF", 8'hFF, 16'h00AA);
        do_read("rdFF_p0", 0, 8'hFF, 16'h00AA);
        do_read("rd20_p1", 1, 8'd20, 16'hBEEF);

        // simultaneous rw load and two reads
        set_rw(1'b1, 1'b0, 8'd20, 16'h0000);
        set_r(0, 1'b1, 8'd7);
        set_r(1, 1'b1, 8'd20);
        step();
        check("tri_n1_rw_rdy", 32'(rw_rdy), 32'd1);
        check("tri_n1_rw_rdata", 32'(rw_rdata), 32'hBEEF);
        check("tri_n1_r_rdy", 32'(r_rdy), 32'd0);
        set_rw(1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("tri_n2_rw_rdy", 32'(rw_rdy), 32'd0);
        check("tri_n2_r_rdy", 32'(r_rdy), 32'b01);
        check("tri_n2_data0", 32'(r_data[0]), 32'h7777);
        set_r(0, 1'b0, 8'h00);
        step();
        check("tri_n3_r_rdy", 32'(r_rdy), 32'b10);
        check("tri_n3_data1", 32'(r_data[1]), 32'hBEEF);
        check("tri_n3_data0", 32'(r_data[0]), 32'd0);
        set_r(1, 1'b0, 8'h00);
        step();
        check("tri_quiet", {15'd0, rw_rdy, 14'd0, r_rdy}, 32'd0);

        // both read ports requesting continuously: grants alternate
        set_r(0, 1'b1, 8'd7);
        set_r(1, 1'b1, 8'd20);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("alt_rdy_c%0d", c), 32'(r_rdy), (c % 2 == 0) ? 32'b01 : 32'b10);
            check($sformatf("alt_data_c%0d", c), r_data,
                  (c % 2 == 0) ? 32'h0000_7777 : 32'hBEEF_0000);
        end
        set_r(0, 1'b0, 8'h00);
        set_r(1, 1'b0, 8'h00);
        step();
        check("alt_quiet", 32'(r_rdy), 32'd0);

        // val dropped before rdy: the completion pulse still follows
        set_r(1, 1'b1, 8'd7);
        step();
        set_r(1, 1'b0, 8'h00);
        check("drop_rdy", 32'(r_rdy), 32'b10);
        check("drop_data", 32'(r_data[1]), 32'h7777);
        step();
        check("drop_quiet", 32'(r_rdy), 32'd0);

        // single port held: completes every second cycle
        set_r(0, 1'b1, 8'hFF);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("b2b_rdy_c%0d", c), 32'(r_rdy), (c % 2 == 0) ? 32'b01 : 32'b00);
            check($sformatf("b2b_data_c%0d", c), 32'(r_data[0]), (c % 2 == 0) ? 32'h00AA : 32'h0);
        end
        set_r(0, 1'b0, 8'h00);
        step();
        check("b2b_quiet", 32'(r_rdy), 32'd0);

        // store granted in N, read of same address granted in N+1
        set_rw(1'b1, 1'b1, 8'd10, 16'h1234);
        set_r(0, 1'b1, 8'd10);
        step();
        check("raw_rw_rdy", 32'(rw_rdy), 32'd1);
        check("raw_rw_rdata", 32'(rw_rdata), 32'h1234);
        check("raw_r_rdy_n1", 32'(r_rdy), 32'd0);
        set_rw(1'b0, 1'b0, 8'h00, 16'h0000);
        step();
        check("raw_r_rdy_n2", 32'(r_rdy), 32'b01);
        check("raw_data", 32'(r_data[0]), 32'h1234);
        set_r(0, 1'b0, 8'h00);
        step();

        // reset during a rdy cycle and a store grant cycle
        set_r(0, 1'b1, 8'd10);
        step();
        check("prerst_rdy", 32'(r_rdy), 32'b01);
        check("prerst_data", 32'(r_data[0]), 32'h1234);
        set_r(0, 1'b0, 8'h00);
        set_rw(1'b1, 1'b1, 8'd30, 16'h5555);
        #3;
        arst_ni = 1'b0;
        #1;
        check("rst_clr_r_rdy", 32'(r_rdy), 32'd0);
        check("rst_clr_r_data", r_data, 32'd0);
        check("rst_clr_rw_rdy", 32'(rw_rdy), 32'd0);
        step();
        check("rst_no_rw_rdy", 32'(rw_rdy), 32'd0);
        check("rst_no_rw_rdata", 32'(rw_rdata), 32'd0);
        set_rw(1'b0, 1'b0, 8'h00, 16'h0000);
        arst_ni = 1'b1;
        step();
        check("post_rst_idle", {15'd0, rw_rdy, 14'd0, r_rdy}, 32'd0);
        step();
        do_read("rd30_after_rst", 0, 8'd30, 16'h0000);
        do_read("rd10_after_rst", 1, 8'd10, 16'h1234);
        do_read("rd20_after_rst", 0, 8'd20, 16'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter RPORTS, default 2 (`MEM_RPORTS), number of instruction-fetch read ports.
REQ-002 SHALL have parameter DEPTH, default 256, words of storage; address width fixed at 8.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i, arst_ni.
REQ-004 SHALL have these ports:
- clk_i  in  1  clock
- arst_ni  in  1  async active-low reset
- mem_r_intf[i].val  in  1  read request, held by master until rdy
- mem_r_intf[i].addr  in  8  read address
- mem_r_intf[i].rdy  out  1  one-cycle completion pulse
- mem_r_intf[i].data  out  16  read data, valid when rdy
- mem_rw_intf.val  in  1  load/store request, held until rdy
- mem_rw_intf.wen  in  1  1=store, 0=load
- mem_rw_intf.addr  in  8  address
- mem_rw_intf.wdata  in  16  store data
- mem_rw_intf.rdy  out  1  one-cycle completion pulse
- mem_rw_intf.rdata  out  16  load data (store: data written), valid when rdy

Function
REQ-005 SHALL be the responder for mem_rport/mem_rwport: master drives val+addr stable until the cycle rdy=1; transfer completes on val&&rdy.
REQ-006 SHALL hold one 16-bit x DEPTH synchronous single-access storage array: at most one read or write per cycle.
REQ-007 SHALL arbitrate each cycle among requesters with val=1 that are not in flight; rw port always wins over read ports.
REQ-008 SHALL exclude a port from arbitration in the cycle its rdy is asserted (its val is still high that cycle).
REQ-009 SHALL perform the array access in grant cycle N; SHALL assert rdy of the granted port in cycle N+1 only, with data/rdata driven from the array that cycle.
REQ-010 SHALL sustain one grant per cycle across ports; a single port completes at most every second cycle.
REQ-011 SHALL commit a store at the end of grant cycle N; rdata in N+1 equals wdata.
REQ-012 SHALL return new data for any read granted in a cycle after a store to the same address (no stale read).
REQ-013 SHALL drive rdy=0 and data/rdata=0 in every cycle not completing a transfer.
REQ-014 SHALL treat addr 8'hFF as ordinary storage (stdin/stdout mapping lives in the LSU).
REQ-015 SHALL, if a master drops val before rdy (protocol violation), still pulse rdy for the in-flight access; no other side effect.
REQ-016 SHALL ignore addr/wdata/wen of non-granted ports.

Reset
REQ-017 SHALL, on arst_ni=0, immediately clear in-flight state, all rdy, data, rdata, and arbitration pointer (to port 0).
REQ-018 SHALL NOT clear storage contents on reset; program survives reset.
REQ-019 SHALL drop an access in flight at reset: a store granted in the reset cycle is not committed, no rdy follows.

Configuration
REQ-020 SHALL honour macro MEM_RR_ARB_EN: defined -> round-robin among read ports, pointer moves to one past the granted port (wrap RPORTS-1 -> 0); undefined -> fixed priority, lowest index wins. rw priority unchanged either way.

Verification
REQ-021 Store M[20]=16'hBEEF on rw, then read port 0 addr 20 -> rw.rdy one cycle after grant with rdata=BEEF; port0 rdy next grant+1 with data=BEEF.
REQ-022 rw load and port0/port1 reads same cycle -> rw.rdy at N+1, port0 rdy N+2, port1 rdy N+3 (fixed priority); exactly one rdy per cycle.
REQ-023 MEM_RR_ARB_EN defined, ports 0 and 1 requesting continuously -> grants alternate 0,1,0,1; undefined -> port 0 granted every second cycle, port 1 fills the gaps.
REQ-024 Store M[10]=1234 granted in cycle N, read of M[10] granted N+1 -> data=1234.
REQ-025 Assert arst_ni=0 in grant cycle of store M[30]=5555 (old 0000) -> no rdy, M[30] reads 0000 after reset; M[10]=1234 preserved.
REQ-026 Read addr FF after store FF=00AA -> data=00AA; back-to-back single-port requests -> rdy every second cycle.
